// File: rtl/iref_ctrl_pkg.sv
// Shared types and default delays for the IREF power-up sequencer.
// Optional periodic recharge is enabled by defining IREF_CTRL_RECHARGE_EN.
package iref_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_CHARGE = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ON     = 2'd3
    } iref_state_e;

    localparam int DEF_CNT_W           = 16;
    localparam int DEF_CHARGE_CYCLES   = 16;
    localparam int DEF_SETTLE_CYCLES   = 8;
    localparam int DEF_RECHARGE_PERIOD = 1024;
    localparam int DEF_RECHARGE_CYCLES = 4;

    // A delay must be loadable as (cycles-1) into a cnt_w-bit counter.
    function automatic bit dly_in_range(input int cycles, input int cnt_w);
        return (cycles >= 1) && (longint'(cycles) < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/iref_dly_cnt.sv
// Loadable down-counter with zero flag; saturates at 0 and never wraps.
// Used for the charge/settle delay and, with IREF_CTRL_RECHARGE_EN, the recharge period.
module iref_dly_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/iref_ctrl.sv
// IREF power-up sequencer: releases pd, times the charge pulse, then settling, then ready.
// Define IREF_CTRL_RECHARGE_EN for periodic charge pulses while ON.
//
// state  | meaning
// OFF    | pd=1, charge=1, ready=0; waiting for en
// CHARGE | pd=0, charge=1; counting CHARGE_CYCLES
// SETTLE | pd=0, charge=0; counting SETTLE_CYCLES
// ON     | pd=0, ready=1; charge=0 (or periodic recharge pulses)
module iref_ctrl
    import iref_ctrl_pkg::*;
#(
    parameter int CHARGE_CYCLES   = DEF_CHARGE_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int RECHARGE_PERIOD = DEF_RECHARGE_PERIOD,
    parameter int RECHARGE_CYCLES = DEF_RECHARGE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       iref_pd,
    output logic       iref_charge,
    output logic       ready,
    output logic [1:0] state
);

    if (!dly_in_range(CHARGE_CYCLES, CNT_W)) begin : g_bad_charge
        $error("iref_ctrl: CHARGE_CYCLES out of range");
    end
    if (!dly_in_range(SETTLE_CYCLES, CNT_W)) begin : g_bad_settle
        $error("iref_ctrl: SETTLE_CYCLES out of range");
    end

    iref_state_e  r_state, w_state_nxt;
    logic         r_pd, w_pd_nxt;
    logic         r_charge, w_charge_nxt;
    logic         r_ready, w_ready_nxt;
    logic         w_dly_load;
    logic [CNT_W-1:0] w_dly_value;
    logic         w_dly_zero;

    iref_dly_cnt #(.W(CNT_W)) u_dly_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_dly_load),
        .i_value (w_dly_value),
        .o_zero  (w_dly_zero)
    );

`ifdef IREF_CTRL_RECHARGE_EN
    localparam int RC_W = $clog2(RECHARGE_PERIOD + 1);

    if (RECHARGE_CYCLES < 1 || RECHARGE_CYCLES >= RECHARGE_PERIOD) begin : g_bad_recharge
        $error("iref_ctrl: RECHARGE_CYCLES must be 1..RECHARGE_PERIOD-1");
    end

    logic            w_rc_load;
    logic [RC_W-1:0] w_rc_value;
    logic            w_rc_zero;

    iref_dly_cnt #(.W(RC_W)) u_rc_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_rc_load),
        .i_value (w_rc_value),
        .o_zero  (w_rc_zero)
    );
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pd_nxt     = r_pd;
        w_charge_nxt = r_charge;
        w_ready_nxt  = r_ready;
        w_dly_load   = 1'b0;
        w_dly_value  = '0;
`ifdef IREF_CTRL_RECHARGE_EN
        w_rc_load    = 1'b0;
        w_rc_value   = '0;
`endif
        if (!en) begin
            w_state_nxt  = ST_OFF;
            w_pd_nxt     = 1'b1;
            w_charge_nxt = 1'b1;
            w_ready_nxt  = 1'b0;
            w_dly_load   = 1'b1;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_CHARGE;
                    w_pd_nxt    = 1'b0;
                    w_dly_load  = 1'b1;
                    w_dly_value = CNT_W'(CHARGE_CYCLES - 1);
                end
                ST_CHARGE: begin
                    if (w_dly_zero) begin
                        w_state_nxt  = ST_SETTLE;
                        w_charge_nxt = 1'b0;
                        w_dly_load   = 1'b1;
                        w_dly_value  = CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
                ST_SETTLE: begin
                    if (w_dly_zero) begin
                        w_state_nxt = ST_ON;
                        w_ready_nxt = 1'b1;
`ifdef IREF_CTRL_RECHARGE_EN
                        w_rc_load   = 1'b1;
                        w_rc_value  = RC_W'(RECHARGE_PERIOD - 1);
`endif
                    end
                end
                ST_ON: begin
`ifdef IREF_CTRL_RECHARGE_EN
                    // The idle delay counter times the pulse width while ON.
                    if (w_rc_zero) begin
                        w_charge_nxt = 1'b1;
                        w_rc_load    = 1'b1;
                        w_rc_value   = RC_W'(RECHARGE_PERIOD - 1);
                        w_dly_load   = 1'b1;
                        w_dly_value  = CNT_W'(RECHARGE_CYCLES - 1);
                    end else if (r_charge && w_dly_zero) begin
                        w_charge_nxt = 1'b0;
                    end
`endif
                end
                default: begin
                    w_state_nxt  = ST_OFF;
                    w_pd_nxt     = 1'b1;
                    w_charge_nxt = 1'b1;
                    w_ready_nxt  = 1'b0;
                    w_dly_load   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_OFF;
            r_pd     <= 1'b1;
            r_charge <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pd     <= w_pd_nxt;
            r_charge <= w_charge_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign iref_pd     = r_pd;
    assign iref_charge = r_charge;
    assign ready       = r_ready;
    assign state       = r_state;

endmodule

// File: tb/tb_iref_ctrl.sv
// Scoreboard bench for iref_ctrl: two instances (4/3 and minimum 1/1 delays) share en/rst.
// Expected pulses are checked when IREF_CTRL_RECHARGE_EN is defined, flat charge otherwise.
module tb_iref_ctrl;

    localparam int NDUT = 2;
    localparam int RC_P = 20;
    localparam int RC_R = 2;
    localparam int C_CYC [NDUT] = '{4, 1};
    localparam int S_CYC [NDUT] = '{3, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic       pd_a, ch_a, rdy_a;
    logic [1:0] st_a;
    logic       pd_b, ch_b, rdy_b;
    logic [1:0] st_b;

    always #5 clk = ~clk;

    iref_ctrl #(.CHARGE_CYCLES(4), .SETTLE_CYCLES(3), .CNT_W(16),
                .RECHARGE_PERIOD(RC_P), .RECHARGE_CYCLES(RC_R)) u_dut_a (
        .clk(clk), .rst(rst), .en(en),
        .iref_pd(pd_a), .iref_charge(ch_a), .ready(rdy_a), .state(st_a)
    );

    iref_ctrl #(.CHARGE_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(16),
                .RECHARGE_PERIOD(RC_P), .RECHARGE_CYCLES(RC_R)) u_dut_b (
        .clk(clk), .rst(rst), .en(en),
        .iref_pd(pd_b), .iref_charge(ch_b), .ready(rdy_b), .state(st_b)
    );

    typedef struct {
        logic [4:0] exp [NDUT];
    } exp_t;

    exp_t  sb_q [$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    string tname = "init";

    bit m_act [NDUT] = '{0, 0};
    int m_el  [NDUT] = '{0, 0};

    // Expected {pd, charge, ready, state} from elapsed cycles since the enabling edge.
    function automatic logic [4:0] model_out(input bit act, input int el, input int c, input int s);
        int on_t;
        if (!act) return 5'b1_1_0_00;
        if (el < c) return 5'b0_1_0_01;
        if (el < c + s) return 5'b0_0_0_10;
        on_t = el - (c + s);
`ifdef IREF_CTRL_RECHARGE_EN
        if (on_t >= RC_P && (on_t % RC_P) < RC_R) return 5'b0_1_1_11;
`endif
        return 5'b0_0_1_11;
    endfunction

    task automatic step(input logic e, input logic r);
        exp_t       x;
        exp_t       got_x;
        logic [4:0] got [NDUT];
        en  = e;
        rst = r;
        for (int k = 0; k < NDUT; k++) begin
            if (r || !e) begin
                m_act[k] = 1'b0;
                m_el[k]  = 0;
            end else if (!m_act[k]) begin
                m_act[k] = 1'b1;
                m_el[k]  = 0;
            end else begin
                m_el[k]  = m_el[k] + 1;
            end
            x.exp[k] = model_out(m_act[k], m_el[k], C_CYC[k], S_CYC[k]);
        end
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
        got[0] = {pd_a, ch_a, rdy_a, st_a};
        got[1] = {pd_b, ch_b, rdy_b, st_b};
        got_x = sb_q.pop_front();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (got[k] !== got_x.exp[k]) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: got pd,charge,ready,state=%b expected %b",
                         tname, k, cyc, got[k], got_x.exp[k]);
            end
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        repeat (3) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);
    endtask

    task automatic test_sequence();
        tname = "sequence";
        repeat (10) step(1'b1, 1'b0);
        tname = "abort_on";
        repeat (6) step(1'b0, 1'b0);
    endtask

    task automatic test_abort_charge();
        tname = "abort_charge";
        repeat (2) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
    endtask

    task automatic test_rst_mid();
        tname = "rst_mid";
        repeat (5) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (9) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
    endtask

    task automatic test_recharge();
        tname = "recharge";
        repeat (60) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic e;
        tname = "random";
        e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) e = ~e;
            step(e, ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_abort_charge();
        test_rst_mid();
        test_recharge();
        test_random();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
